// File: rtl/ram_port_arbiter_if.sv
// Bundle of the CPU, diagnostics and RAM-side signals around the RAM port arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [7:0]            cpu_wdata;
    logic [7:0]            cpu_rdata;
    logic                  cpu_ack;
    logic                  cpu_overrun;

    logic                  diag_req;
    logic                  diag_we;
    logic [ADDR_WIDTH-1:0] diag_addr;
    logic [7:0]            diag_wdata;
    logic [7:0]            diag_rdata;
    logic                  diag_ack;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [7:0]            ram_wdata;
    logic [7:0]            ram_rdata;
    logic                  ram_we;
    logic                  ram_cs;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  diag_req, diag_we, diag_addr, diag_wdata,
        input  ram_rdata,
        output cpu_rdata, cpu_ack, cpu_overrun,
        output diag_rdata, diag_ack,
        output ram_addr, ram_wdata, ram_we, ram_cs
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output diag_req, diag_we, diag_addr, diag_wdata,
        output ram_rdata,
        input  cpu_rdata, cpu_ack, cpu_overrun,
        input  diag_rdata, diag_ack,
        input  ram_addr, ram_wdata, ram_we, ram_cs
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port emulation RAM between the CPU bus (priority) and the
// diagnostics engine, with an anti-starvation limit; all RAM-side outputs are registered.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int CPU_CYCLES = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              fpga_clk,
    input  logic              fpga_reset,
    ram_port_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        DIAG_SETUP,
        DIAG_STROBE,
        DIAG_DONE
    } state_t;

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [3:0]            r_starve;
    logic                  r_diag_req;
    logic                  r_cpu_pending;
    logic                  r_cpu_we;
    logic [ADDR_WIDTH-1:0] r_cpu_addr;
    logic [7:0]            r_cpu_wdata;
    logic                  r_act_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [7:0]            r_ram_wdata;
    logic                  r_ram_we;
    logic                  r_ram_cs;
    logic                  r_cpu_ack;
    logic                  r_diag_ack;
    logic [7:0]            r_cpu_rdata;
    logic [7:0]            r_diag_rdata;
    logic                  r_cpu_overrun;

    state_t                w_state_next;
    logic [2:0]            w_cnt;
    logic [3:0]            w_starve;
    logic                  w_grant_cpu;
    logic                  w_grant_diag;
    logic                  w_ram_cs;
    logic                  w_ram_we;
    logic                  w_cpu_ack;
    logic                  w_diag_ack;
    logic                  w_cpu_cap;
    logic                  w_diag_cap;

    // Outputs are registered, so the combinational block computes the values
    // the RAM lines must carry during the *next* state.
    always_comb begin
        w_state_next = r_state;
        w_cnt        = r_cnt;
        w_starve     = r_starve;
        w_grant_cpu  = 1'b0;
        w_grant_diag = 1'b0;
        w_ram_cs     = 1'b0;
        w_ram_we     = 1'b0;
        w_cpu_ack    = 1'b0;
        w_diag_ack   = 1'b0;
        w_cpu_cap    = 1'b0;
        w_diag_cap   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_diag_req && (r_starve == 4'(STARVE_MAX))) begin
                    w_grant_diag = 1'b1;
                end else if (r_cpu_pending) begin
                    w_grant_cpu = 1'b1;
                    if (r_diag_req && (r_starve < 4'(STARVE_MAX))) begin
                        w_starve = r_starve + 4'd1;
                    end
                end else if (r_diag_req) begin
                    w_grant_diag = 1'b1;
                end
                if (w_grant_cpu) begin
                    w_state_next = CPU_ACC;
                    w_cnt        = 3'd0;
                    w_ram_cs     = 1'b1;
                end else if (w_grant_diag) begin
                    w_state_next = DIAG_SETUP;
                    w_starve     = 4'd0;
                    w_ram_cs     = 1'b1;
                end
            end
            CPU_ACC: begin
                if (r_cnt == 3'(CPU_CYCLES - 1)) begin
                    w_state_next = IDLE;
                    w_cpu_ack    = 1'b1;
                    w_cpu_cap    = ~r_act_we;
                end else begin
                    w_cnt    = r_cnt + 3'd1;
                    w_ram_cs = 1'b1;
                    w_ram_we = r_act_we && (r_cnt == 3'(CPU_CYCLES - 2));
                end
            end
            DIAG_SETUP: begin
                w_state_next = DIAG_STROBE;
                w_ram_cs     = 1'b1;
                w_ram_we     = r_act_we;
            end
            DIAG_STROBE: begin
                w_state_next = DIAG_DONE;
                w_ram_cs     = 1'b1;
                w_diag_ack   = 1'b1;
                w_diag_cap   = 1'b1;
            end
            DIAG_DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (!fpga_reset) begin
            r_state       <= IDLE;
            r_cnt         <= 3'd0;
            r_starve      <= 4'd0;
            r_diag_req    <= 1'b0;
            r_cpu_pending <= 1'b0;
            r_cpu_we      <= 1'b0;
            r_cpu_addr    <= '0;
            r_cpu_wdata   <= 8'd0;
            r_act_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= 8'd0;
            r_ram_we      <= 1'b0;
            r_ram_cs      <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_diag_ack    <= 1'b0;
            r_cpu_rdata   <= 8'd0;
            r_diag_rdata  <= 8'd0;
            r_cpu_overrun <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt;
            r_starve   <= w_starve;
            r_ram_cs   <= w_ram_cs;
            r_ram_we   <= w_ram_we;
            r_cpu_ack  <= w_cpu_ack;
            r_diag_ack <= w_diag_ack;
            // A level still high while DIAG_DONE is acknowledged belongs to the
            // finished access; only a level seen in the following IDLE is new.
            r_diag_req <= (r_state == DIAG_DONE) ? 1'b0 : bus.diag_req;

            if (w_grant_cpu) begin
                r_ram_addr  <= r_cpu_addr;
                r_ram_wdata <= r_cpu_wdata;
                r_act_we    <= r_cpu_we;
            end else if (w_grant_diag) begin
                r_ram_addr  <= bus.diag_addr;
                r_ram_wdata <= bus.diag_wdata;
                r_act_we    <= bus.diag_we;
            end

            if (bus.cpu_req) begin
                if (r_cpu_pending && !w_grant_cpu) begin
                    r_cpu_overrun <= 1'b1;
                end else begin
                    r_cpu_pending <= 1'b1;
                    r_cpu_we      <= bus.cpu_we;
                    r_cpu_addr    <= bus.cpu_addr;
                    r_cpu_wdata   <= bus.cpu_wdata;
                end
            end else if (w_grant_cpu) begin
                r_cpu_pending <= 1'b0;
            end

            if (w_cpu_cap) begin
                r_cpu_rdata <= bus.ram_rdata;
            end
            if (w_diag_cap) begin
                r_diag_rdata <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wdata   = r_ram_wdata;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_cs      = r_ram_cs;
    assign bus.cpu_ack     = r_cpu_ack;
    assign bus.diag_ack    = r_diag_ack;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.diag_rdata  = r_diag_rdata;
    assign bus.cpu_overrun = r_cpu_overrun;

endmodule
